// File: rtl/mux_arbiter_if.sv
// Bundles both requester channels and the shared output channel of the arbiter.
// The arbiter takes the master side; the producers and the consumer take the slave side.
interface mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             sel;
  logic             busy;

  modport master (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, out_valid, out_data, sel, busy
  );

  modport slave (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, out_valid, out_data, sel, busy
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel between requesters A and B,
// with each grant bounded to MAX_BURST accepted beats while the other side is waiting.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.master bus
);
  localparam int                 CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             last_b_q, last_b_d;

  logic             req_a, req_b, out_ready;
  logic [WIDTH-1:0] data_a, data_b;
  logic             ack_a, ack_b, out_valid;
  logic [WIDTH-1:0] out_data;

  assign req_a     = bus.req_a;
  assign req_b     = bus.req_b;
  assign data_a    = bus.data_a;
  assign data_b    = bus.data_b;
  assign out_ready = bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      last_b_q <= last_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_b_d  = last_b_q;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_b_q)) begin
          state_d = GRANT_A;
        end else if (req_b) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        out_valid = req_a;
        out_data  = req_a ? data_a : '0;
        ack_a     = req_a & out_ready;
        if (!req_a) begin
          state_d = req_b ? GRANT_B : IDLE;
        end else if (ack_a) begin
          // At the burst limit, hand over if B waits, otherwise restart the count
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (req_b) state_d = GRANT_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GRANT_B: begin
        out_valid = req_b;
        out_data  = req_b ? data_b : '0;
        ack_b     = req_b & out_ready;
        if (!req_b) begin
          state_d = req_a ? GRANT_A : IDLE;
        end else if (ack_b) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (req_a) state_d = GRANT_A;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Entering a grant restarts the burst and records who was served
    if (state_d == GRANT_A && state_q != GRANT_A) begin
      cnt_d    = '0;
      sel_d    = 1'b0;
      last_b_d = 1'b0;
    end
    if (state_d == GRANT_B && state_q != GRANT_B) begin
      cnt_d    = '0;
      sel_d    = 1'b1;
      last_b_d = 1'b1;
    end

    // Nothing is accepted or presented while reset is asserted
    if (rst) begin
      ack_a     = 1'b0;
      ack_b     = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
    end
  end

  assign bus.ack_a     = ack_a;
  assign bus.ack_b     = ack_b;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q != IDLE) && !rst;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: a MAX_BURST=4 instance checked throughout and a
// MAX_BURST=1 instance, fed the same inputs, checked for strict alternation.
module tb_mux_arbiter;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_b;

  mux_arbiter_if #(.WIDTH(WIDTH)) bus0 ();
  mux_arbiter_if #(.WIDTH(WIDTH)) bus1 ();

  mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  assign bus1.req_a     = bus0.req_a;
  assign bus1.data_a    = bus0.data_a;
  assign bus1.req_b     = bus0.req_b;
  assign bus1.data_b    = bus0.data_b;
  assign bus1.out_ready = bus0.out_ready;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then settle to the falling edge.
  task automatic tick(input logic r, input logic ra, input logic [7:0] da,
                      input logic rb, input logic [7:0] db, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    bus0.req_a     = ra;
    bus0.data_a    = da;
    bus0.req_b     = rb;
    bus0.data_b    = db;
    bus0.out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic aa, input logic ab, input logic s, input logic b);
    chk({tag, ".valid"}, 32'(bus0.out_valid), 32'(v));
    chk({tag, ".data"},  32'(bus0.out_data),  32'(d));
    chk({tag, ".ack_a"}, 32'(bus0.ack_a),     32'(aa));
    chk({tag, ".ack_b"}, 32'(bus0.ack_b),     32'(ab));
    chk({tag, ".sel"},   32'(bus0.sel),       32'(s));
    chk({tag, ".busy"},  32'(bus0.busy),      32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.req_a     = 1'b0;
    bus0.data_a    = '0;
    bus0.req_b     = 1'b0;
    bus0.data_b    = '0;
    bus0.out_ready = 1'b0;

    // Reset held with both sides requesting
    tick(1, 1, 8'hA5, 1, 8'h5B, 1);
    chk_out("rst0", 0, 8'h00, 0, 0, 0, 0);
    tick(1, 1, 8'hA5, 1, 8'h5B, 1);
    chk_out("rst1", 0, 8'h00, 0, 0, 0, 0);
    tick(0, 1, 8'hA5, 1, 8'h5B, 1);
    chk_out("rst_rel", 0, 8'h00, 0, 0, 0, 0);
    chk("alt_idle.sel", 32'(bus1.sel), 32'd0);

    // Contention: 4 A, 4 B, 4 A on the MAX_BURST=4 unit, A,B,A,B on the MAX_BURST=1 unit
    for (int k = 0; k < 12; k++) begin
      tick(0, 1, 8'hA5, 1, 8'h5B, 1);
      exp_b = (k / 4) % 2;
      chk_out($sformatf("cont%0d", k), 1, (exp_b != 0) ? 8'h5B : 8'hA5,
              exp_b == 0, exp_b != 0, exp_b != 0, 1);
      chk($sformatf("alt%0d.sel", k), 32'(bus1.sel), 32'(k % 2));
      chk($sformatf("alt%0d.ack_b", k), 32'(bus1.ack_b), 32'(k % 2));
    end

    // Both withdraw: release cycle in GRANT_B, then IDLE keeps sel
    tick(0, 0, 8'hA5, 0, 8'h5B, 1);
    chk_out("drop", 0, 8'h00, 0, 0, 1, 1);
    tick(0, 0, 8'h00, 0, 8'h00, 1);
    chk_out("idle", 0, 8'h00, 0, 0, 1, 0);

    // Single requester A, six beats, burst limit must not release the grant
    tick(0, 1, 8'h11, 0, 8'h00, 1);
    chk_out("single_req", 0, 8'h00, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(0, 1, 8'(8'h10 + k), 0, 8'h00, 1);
      chk_out($sformatf("single%0d", k), 1, 8'(8'h10 + k), 1, 0, 0, 1);
    end
    tick(0, 0, 8'h16, 0, 8'h00, 1);
    chk_out("single_rel", 0, 8'h00, 0, 0, 0, 1);
    tick(0, 0, 8'h00, 0, 8'h00, 1);
    chk_out("single_idle", 0, 8'h00, 0, 0, 0, 0);

    // Backpressure in GRANT_B: ready 1,0,0,1,1 gives three accepted beats
    tick(0, 0, 8'h00, 1, 8'h30, 1);
    chk_out("bp_req", 0, 8'h00, 0, 0, 0, 0);
    tick(0, 0, 8'h00, 1, 8'h30, 1);
    chk_out("bp0", 1, 8'h30, 0, 1, 1, 1);
    tick(0, 0, 8'h00, 1, 8'h31, 0);
    chk_out("bp1", 1, 8'h31, 0, 0, 1, 1);
    tick(0, 0, 8'h00, 1, 8'h31, 0);
    chk_out("bp2", 1, 8'h31, 0, 0, 1, 1);
    tick(0, 0, 8'h00, 1, 8'h31, 1);
    chk_out("bp3", 1, 8'h31, 0, 1, 1, 1);
    tick(0, 0, 8'h00, 1, 8'h32, 1);
    chk_out("bp4", 1, 8'h32, 0, 1, 1, 1);
    // Fourth accepted beat of this grant hits the limit while A now waits
    tick(0, 1, 8'h40, 1, 8'h33, 1);
    chk_out("bp_last", 1, 8'h33, 0, 1, 1, 1);
    tick(0, 1, 8'h40, 1, 8'h34, 1);
    chk_out("bp_switch", 1, 8'h40, 1, 0, 0, 1);

    // Release handoff after two A beats
    tick(0, 1, 8'h41, 1, 8'h34, 1);
    chk_out("ho_a2", 1, 8'h41, 1, 0, 0, 1);
    tick(0, 0, 8'h42, 1, 8'h34, 1);
    chk_out("ho_gap", 0, 8'h00, 0, 0, 0, 1);
    tick(0, 0, 8'h42, 1, 8'h34, 1);
    chk_out("ho_b", 1, 8'h34, 0, 1, 1, 1);

    // Reset mid-burst: two A beats, then rst with both requesting
    tick(0, 1, 8'h50, 0, 8'h35, 1);
    chk_out("mr_rel", 0, 8'h00, 0, 0, 1, 1);
    tick(0, 1, 8'h50, 0, 8'h35, 1);
    chk_out("mr_a1", 1, 8'h50, 1, 0, 0, 1);
    tick(0, 1, 8'h51, 1, 8'h60, 1);
    chk_out("mr_a2", 1, 8'h51, 1, 0, 0, 1);
    tick(1, 1, 8'h52, 1, 8'h60, 1);
    chk("mr_rst.ack_a", 32'(bus0.ack_a), 32'd0);
    chk("mr_rst.ack_b", 32'(bus0.ack_b), 32'd0);
    tick(0, 1, 8'h52, 1, 8'h60, 1);
    chk_out("mr_idle", 0, 8'h00, 0, 0, 0, 0);
    tick(0, 1, 8'h52, 1, 8'h60, 1);
    chk_out("mr_regrant", 1, 8'h52, 1, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
